instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//  Instruction decoder of the 16-bit CPU core. It sits between the fetch stage and the register file, ALU, PC and memory units.
//  Each cycle it registers one 16-bit instruction word (ins) and one 16-bit extension word (ext).
//  It expands them into per-unit control signals, valid one cycle later.
// PARAMETERS
//  none; all widths are fixed by the ISA.
// PORTS
//  cpu_clk     in   1  sole clock; all state updates on rising edge
//  cpu_rst     in   1  synchronous, active-high reset
//  ins         in   16 instruction word
//  ins_en      in   1  ins/ext valid this cycle
//  ext         in   16 extension word (ALU function / branch offset)
//  imm_en      out  1  B operand taken from arg_imm instead of the register file
//  arg_imm     out  5  immediate: {ins[3],ins[3:0]}, sign-extended nibble
//  read_a      out  1  read register arg_a
//  arg_a       out  4  register A index
//  read_b      out  1  read register src_b
//  src_b       out  4  register B index
//  set_pc      out  1  load PC absolutely
//  add_pc      out  1  add an offset to PC
//  inc_pc      out  1  PC += 1
//  pc_src      out  2  PC operand: 0=reg A, 1=ext, 2=imm, 3=reserved
//  cmp_b       out  3  branch condition code
//  out_regs    out  3  output-port register write enables
//  alu_en      out  1  ALU result valid / writeback
//  sh_off_imm  out  1  shift amount from imm rather than from reg B
//  truth_table out  4  logic-unit truth table
//  alu_op      out  5  ALU function select
//  dst         out  4  destination register; 0 = no writeback
//  mem_en      out  1  memory access
//  mem_write   out  1  1=store, 0=load (valid only when mem_en=1)
// BEHAVIOUR
//  - All outputs are registered, with 1-cycle latency: ins/ext sampled at edge N drive the outputs from edge N to edge N+1.
//  - cpu_rst=1 at an edge: every output becomes 0. Reset wins over ins_en.
//  - ins_en=0 at an edge: every output becomes 0 (bubble), including inc_pc.
//  - Any field not used by the decoded opcode is driven to 0.
//  - Opcode op=ins[15:12]. Register fields: D=ins[11:8], A=ins[7:4], B=ins[3:0].
//  - Opcode table (every listed op also sets inc_pc=1 unless noted):
//    0x0 NOP : no other outputs.
//    0x1 ALUR: read_a=read_b=alu_en=1; arg_a=A, src_b=B, dst=D;
//              alu_op=ext[4:0], truth_table=ext[8:5].
//    0x2 ALUI: as ALUR, but read_b=0, src_b=0, imm_en=1, arg_imm=sext(B), sh_off_imm=ext[9].
//    0x3 LOAD: mem_en=1, mem_write=0, read_a=1, arg_a=A, dst=D, imm_en=1, arg_imm=sext(B) (offset).
//    0x4 STOR: mem_en=mem_write=1, read_a=read_b=1, arg_a=A, src_b=B, dst=0.
//    0x5 JMP : set_pc=1, inc_pc=0, pc_src=ins[9:8]; read_a=1 and arg_a=A only when pc_src=0.
//    0x6 BRC : add_pc=1, inc_pc=0, pc_src=1; read_a=read_b=1, arg_a=A, src_b=B; cmp_b=ins[10:8].
//              The PC unit takes the branch if the condition holds, else it increments.
//    0x7 OUT : read_a=1, arg_a=A, out_regs=ins[10:8].
//    0x8-0xF : reserved; decode as NOP (inc_pc=1 only).
//  - set_pc and add_pc are never both 1. inc_pc=0 whenever either of them is 1.
//  - Back-to-back ins_en=1 decodes one instruction per cycle, with no internal state beyond the output registers.
// TESTING
//  - Reset: cpu_rst=1 with ins=0x1234, ins_en=1 -> next cycle all outputs 0.
//  - ALUR: ins=0x1A53, ext=0x0125 -> alu_en=1, dst=0xA, arg_a=5, src_b=3, alu_op=5, truth_table=9, inc_pc=1, imm_en=0.
//  - ALUI: ins=0x232F, ext=0x0200 -> imm_en=1, arg_imm=5'h1F, sh_off_imm=1, read_b=0, dst=3, arg_a=2.
//  - Memory: ins=0x4071 -> mem_en=1, mem_write=1, arg_a=7, src_b=1, dst=0.
//            ins=0x3470 -> mem_en=1, mem_write=0, dst=4.
//  - Control flow: ins=0x5100 -> set_pc=1, pc_src=1, inc_pc=0, read_a=0.
//                  ins=0x6512 -> add_pc=1, cmp_b=5, arg_a=1, src_b=2, inc_pc=0.
//  - Bubble and reserved: ins_en=0 -> all 0 next cycle; ins=0xF123 -> only inc_pc=1.
//    Alternating ins_en each cycle is followed with exact 1-cycle latency.

Source files
------------

// File: rtl/instr_decode_if.sv
//==============================================================================
// Module  : instr_decode_if
// Brief   : Fetch-to-decoder bus: instruction/extension words in, control out.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface instr_decode_if;
  logic [15:0] ins;
  logic        ins_en;
  logic [15:0] ext;

  logic        imm_en;
  logic [4:0]  arg_imm;
  logic        read_a;
  logic [3:0]  arg_a;
  logic        read_b;
  logic [3:0]  src_b;
  logic        set_pc;
  logic        add_pc;
  logic        inc_pc;
  logic [1:0]  pc_src;
  logic [2:0]  cmp_b;
  logic [2:0]  out_regs;
  logic        alu_en;
  logic        sh_off_imm;
  logic [3:0]  truth_table;
  logic [4:0]  alu_op;
  logic [3:0]  dst;
  logic        mem_en;
  logic        mem_write;

  modport master (
    output ins, ins_en, ext,
    input  imm_en, arg_imm, read_a, arg_a, read_b, src_b,
           set_pc, add_pc, inc_pc, pc_src, cmp_b, out_regs,
           alu_en, sh_off_imm, truth_table, alu_op, dst, mem_en, mem_write
  );

  modport slave (
    input  ins, ins_en, ext,
    output imm_en, arg_imm, read_a, arg_a, read_b, src_b,
           set_pc, add_pc, inc_pc, pc_src, cmp_b, out_regs,
           alu_en, sh_off_imm, truth_table, alu_op, dst, mem_en, mem_write
  );
endinterface

`default_nettype wire

// File: rtl/instr_decode.sv
//==============================================================================
// Module  : instr_decode
// Brief   : 16-bit ISA decoder; expands ins/ext into registered unit controls.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decode (
  input  logic           cpu_clk,
  input  logic           cpu_rst,
  instr_decode_if.slave  bus
);

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_alur = 4'h1;
  localparam logic [3:0] c_op_alui = 4'h2;
  localparam logic [3:0] c_op_load = 4'h3;
  localparam logic [3:0] c_op_stor = 4'h4;
  localparam logic [3:0] c_op_jmp  = 4'h5;
  localparam logic [3:0] c_op_brc  = 4'h6;
  localparam logic [3:0] c_op_out  = 4'h7;

  logic [3:0] w_op;
  logic [3:0] w_fd;
  logic [3:0] w_fa;
  logic [3:0] w_fb;
  logic [4:0] w_sext;
  logic       w_ext_unused;

  assign w_op   = bus.ins[15:12];
  assign w_fd   = bus.ins[11:8];
  assign w_fa   = bus.ins[7:4];
  assign w_fb   = bus.ins[3:0];
  assign w_sext = {bus.ins[3], bus.ins[3:0]};
  assign w_ext_unused = ^bus.ext[15:10];

  logic       w_imm_en;
  logic [4:0] w_arg_imm;
  logic       w_read_a;
  logic [3:0] w_arg_a;
  logic       w_read_b;
  logic [3:0] w_src_b;
  logic       w_set_pc;
  logic       w_add_pc;
  logic       w_inc_pc;
  logic [1:0] w_pc_src;
  logic [2:0] w_cmp_b;
  logic [2:0] w_out_regs;
  logic       w_alu_en;
  logic       w_sh_off_imm;
  logic [3:0] w_truth_table;
  logic [4:0] w_alu_op;
  logic [3:0] w_dst;
  logic       w_mem_en;
  logic       w_mem_write;

  // Fields not used by an opcode stay at their zero default.
  always_comb begin
    w_imm_en      = 1'b0;
    w_arg_imm     = 5'd0;
    w_read_a      = 1'b0;
    w_arg_a       = 4'd0;
    w_read_b      = 1'b0;
    w_src_b       = 4'd0;
    w_set_pc      = 1'b0;
    w_add_pc      = 1'b0;
    w_inc_pc      = 1'b0;
    w_pc_src      = 2'd0;
    w_cmp_b       = 3'd0;
    w_out_regs    = 3'd0;
    w_alu_en      = 1'b0;
    w_sh_off_imm  = 1'b0;
    w_truth_table = 4'd0;
    w_alu_op      = 5'd0;
    w_dst         = 4'd0;
    w_mem_en      = 1'b0;
    w_mem_write   = 1'b0;

    if (bus.ins_en) begin
      w_inc_pc = 1'b1;
      case (w_op)
        c_op_nop: ;
        c_op_alur: begin
          w_read_a      = 1'b1;
          w_arg_a       = w_fa;
          w_read_b      = 1'b1;
          w_src_b       = w_fb;
          w_alu_en      = 1'b1;
          w_dst         = w_fd;
          w_alu_op      = bus.ext[4:0];
          w_truth_table = bus.ext[8:5];
        end
        c_op_alui: begin
          w_read_a      = 1'b1;
          w_arg_a       = w_fa;
          w_imm_en      = 1'b1;
          w_arg_imm     = w_sext;
          w_alu_en      = 1'b1;
          w_dst         = w_fd;
          w_alu_op      = bus.ext[4:0];
          w_truth_table = bus.ext[8:5];
          w_sh_off_imm  = bus.ext[9];
        end
        c_op_load: begin
          w_mem_en  = 1'b1;
          w_read_a  = 1'b1;
          w_arg_a   = w_fa;
          w_dst     = w_fd;
          w_imm_en  = 1'b1;
          w_arg_imm = w_sext;
        end
        c_op_stor: begin
          w_mem_en    = 1'b1;
          w_mem_write = 1'b1;
          w_read_a    = 1'b1;
          w_arg_a     = w_fa;
          w_read_b    = 1'b1;
          w_src_b     = w_fb;
        end
        c_op_jmp: begin
          w_set_pc = 1'b1;
          w_inc_pc = 1'b0;
          w_pc_src = bus.ins[9:8];
          // Register A is only a PC operand when pc_src selects it.
          if (bus.ins[9:8] == 2'd0) begin
            w_read_a = 1'b1;
            w_arg_a  = w_fa;
          end
        end
        c_op_brc: begin
          w_add_pc = 1'b1;
          w_inc_pc = 1'b0;
          w_pc_src = 2'd1;
          w_read_a = 1'b1;
          w_arg_a  = w_fa;
          w_read_b = 1'b1;
          w_src_b  = w_fb;
          w_cmp_b  = bus.ins[10:8];
        end
        c_op_out: begin
          w_read_a   = 1'b1;
          w_arg_a    = w_fa;
          w_out_regs = bus.ins[10:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      bus.imm_en      <= 1'b0;
      bus.arg_imm     <= 5'd0;
      bus.read_a      <= 1'b0;
      bus.arg_a       <= 4'd0;
      bus.read_b      <= 1'b0;
      bus.src_b       <= 4'd0;
      bus.set_pc      <= 1'b0;
      bus.add_pc      <= 1'b0;
      bus.inc_pc      <= 1'b0;
      bus.pc_src      <= 2'd0;
      bus.cmp_b       <= 3'd0;
      bus.out_regs    <= 3'd0;
      bus.alu_en      <= 1'b0;
      bus.sh_off_imm  <= 1'b0;
      bus.truth_table <= 4'd0;
      bus.alu_op      <= 5'd0;
      bus.dst         <= 4'd0;
      bus.mem_en      <= 1'b0;
      bus.mem_write   <= 1'b0;
    end else begin
      bus.imm_en      <= w_imm_en;
      bus.arg_imm     <= w_arg_imm;
      bus.read_a      <= w_read_a;
      bus.arg_a       <= w_arg_a;
      bus.read_b      <= w_read_b;
      bus.src_b       <= w_src_b;
      bus.set_pc      <= w_set_pc;
      bus.add_pc      <= w_add_pc;
      bus.inc_pc      <= w_inc_pc;
      bus.pc_src      <= w_pc_src;
      bus.cmp_b       <= w_cmp_b;
      bus.out_regs    <= w_out_regs;
      bus.alu_en      <= w_alu_en;
      bus.sh_off_imm  <= w_sh_off_imm;
      bus.truth_table <= w_truth_table;
      bus.alu_op      <= w_alu_op;
      bus.dst         <= w_dst;
      bus.mem_en      <= w_mem_en;
      bus.mem_write   <= w_mem_write;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_decode.sv
//==============================================================================
// Module  : tb_instr_decode
// Brief   : Directed-vector bench for instr_decode with hand-computed controls.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_decode;

  typedef struct packed {
    logic       imm_en;
    logic [4:0] arg_imm;
    logic       read_a;
    logic [3:0] arg_a;
    logic       read_b;
    logic [3:0] src_b;
    logic       set_pc;
    logic       add_pc;
    logic       inc_pc;
    logic [1:0] pc_src;
    logic [2:0] cmp_b;
    logic [2:0] out_regs;
    logic       alu_en;
    logic       sh_off_imm;
    logic [3:0] truth_table;
    logic [4:0] alu_op;
    logic [3:0] dst;
    logic       mem_en;
    logic       mem_write;
  } ctl_t;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  instr_decode_if bus ();

  instr_decode dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic ctl_t sample();
    ctl_t s;
    s.imm_en      = bus.imm_en;
    s.arg_imm     = bus.arg_imm;
    s.read_a      = bus.read_a;
    s.arg_a       = bus.arg_a;
    s.read_b      = bus.read_b;
    s.src_b       = bus.src_b;
    s.set_pc      = bus.set_pc;
    s.add_pc      = bus.add_pc;
    s.inc_pc      = bus.inc_pc;
    s.pc_src      = bus.pc_src;
    s.cmp_b       = bus.cmp_b;
    s.out_regs    = bus.out_regs;
    s.alu_en      = bus.alu_en;
    s.sh_off_imm  = bus.sh_off_imm;
    s.truth_table = bus.truth_table;
    s.alu_op      = bus.alu_op;
    s.dst         = bus.dst;
    s.mem_en      = bus.mem_en;
    s.mem_write   = bus.mem_write;
    return s;
  endfunction

  // Drive on the falling edge, then step just past the next rising edge.
  task automatic drive(input logic r, input logic [15:0] i, input logic en,
                       input logic [15:0] x);
    @(negedge cpu_clk);
    cpu_rst    = r;
    bus.ins    = i;
    bus.ins_en = en;
    bus.ext    = x;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    ctl_t e;
    drive(1'b0, 16'h1A53, 1'b1, 16'h0125);
    drive(1'b1, 16'h1234, 1'b1, 16'h0125);
    e = '0;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL reset: got %h want %h", sample(), e);
    end
  endtask

  task automatic test_alu();
    ctl_t e;
    drive(1'b0, 16'h1A53, 1'b1, 16'h0125);
    e = '0;
    e.read_a = 1'b1; e.arg_a = 4'h5; e.read_b = 1'b1; e.src_b = 4'h3;
    e.alu_en = 1'b1; e.dst = 4'hA; e.alu_op = 5'd5; e.truth_table = 4'd9;
    e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL alur: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h232F, 1'b1, 16'h0200);
    e = '0;
    e.read_a = 1'b1; e.arg_a = 4'h2; e.imm_en = 1'b1; e.arg_imm = 5'h1F;
    e.sh_off_imm = 1'b1; e.alu_en = 1'b1; e.dst = 4'h3; e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL alui_neg: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h2A17, 1'b1, 16'hFD33);
    e = '0;
    e.read_a = 1'b1; e.arg_a = 4'h1; e.imm_en = 1'b1; e.arg_imm = 5'h07;
    e.alu_en = 1'b1; e.dst = 4'hA; e.alu_op = 5'h13; e.truth_table = 4'h9;
    e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL alui_pos: got %h want %h", sample(), e);
    end
  endtask

  task automatic test_mem();
    ctl_t e;
    drive(1'b0, 16'h4071, 1'b1, 16'hFFFF);
    e = '0;
    e.mem_en = 1'b1; e.mem_write = 1'b1; e.read_a = 1'b1; e.arg_a = 4'h7;
    e.read_b = 1'b1; e.src_b = 4'h1; e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL store: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h3470, 1'b1, 16'h0000);
    e = '0;
    e.mem_en = 1'b1; e.read_a = 1'b1; e.arg_a = 4'h7; e.dst = 4'h4;
    e.imm_en = 1'b1; e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL load: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h3ED8, 1'b1, 16'h0000);
    e = '0;
    e.mem_en = 1'b1; e.read_a = 1'b1; e.arg_a = 4'hD; e.dst = 4'hE;
    e.imm_en = 1'b1; e.arg_imm = 5'h18; e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL load_neg: got %h want %h", sample(), e);
    end
  endtask

  task automatic test_ctrl();
    ctl_t e;
    drive(1'b0, 16'h5100, 1'b1, 16'h1234);
    e = '0;
    e.set_pc = 1'b1; e.pc_src = 2'd1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL jmp_ext: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h5C34, 1'b1, 16'h0000);
    e = '0;
    e.set_pc = 1'b1; e.pc_src = 2'd0; e.read_a = 1'b1; e.arg_a = 4'h3;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL jmp_reg: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h5E77, 1'b1, 16'h0000);
    e = '0;
    e.set_pc = 1'b1; e.pc_src = 2'd2;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL jmp_imm: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h6512, 1'b1, 16'h00F0);
    e = '0;
    e.add_pc = 1'b1; e.pc_src = 2'd1; e.read_a = 1'b1; e.arg_a = 4'h1;
    e.read_b = 1'b1; e.src_b = 4'h2; e.cmp_b = 3'd5;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL brc: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h7F60, 1'b1, 16'hFFFF);
    e = '0;
    e.read_a = 1'b1; e.arg_a = 4'h6; e.out_regs = 3'd7; e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL out: got %h want %h", sample(), e);
    end
  endtask

  task automatic test_bubble_reserved();
    ctl_t e;
    drive(1'b0, 16'h1A53, 1'b0, 16'h0125);
    e = '0;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL bubble: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'hF123, 1'b1, 16'hFFFF);
    e = '0;
    e.inc_pc = 1'b1;
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL reserved_f: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h8FFF, 1'b1, 16'hFFFF);
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL reserved_8: got %h want %h", sample(), e);
    end

    drive(1'b0, 16'h0FFF, 1'b1, 16'hFFFF);
    n_vec++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL nop: got %h want %h", sample(), e);
    end
  endtask

  // Alternate ins_en each cycle; also check outputs hold while inputs change.
  task automatic test_back_to_back();
    ctl_t e_on;
    ctl_t e_prev;
    ctl_t e_cur;
    e_on = '0;
    e_on.mem_en = 1'b1; e_on.mem_write = 1'b1; e_on.read_a = 1'b1;
    e_on.arg_a = 4'h7; e_on.read_b = 1'b1; e_on.src_b = 4'h1; e_on.inc_pc = 1'b1;
    e_prev = '0;
    e_prev.inc_pc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e_cur = (k % 2 == 0) ? e_on : '0;
      @(negedge cpu_clk);
      cpu_rst    = 1'b0;
      bus.ins    = 16'h4071;
      bus.ins_en = (k % 2 == 0);
      bus.ext    = 16'h0000;
      #1;
      n_vec++;
      if (sample() !== e_prev) begin
        n_err++;
        $display("FAIL b2b_hold[%0d]: got %h want %h", k, sample(), e_prev);
      end
      @(posedge cpu_clk);
      #1;
      n_vec++;
      if (sample() !== e_cur) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h want %h", k, sample(), e_cur);
      end
      e_prev = e_cur;
    end
  endtask

  initial begin
    bus.ins    = 16'h0000;
    bus.ins_en = 1'b0;
    bus.ext    = 16'h0000;
    repeat (3) @(posedge cpu_clk);
    test_reset();
    test_alu();
    test_mem();
    test_ctrl();
    test_bubble_reserved();
    drive(1'b0, 16'h0000, 1'b1, 16'h0000);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
